// File: rtl/mips_mc_controller_if.sv
// Control interface between the multi-cycle MIPS controller and its datapath.
// The master modport is the controller side and the slave modport is the datapath side.
interface mips_mc_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic [1:0] reg_dst;
    logic       data_to_write;
    logic       reg_write;
    logic       alusrc;
    logic [2:0] alu_op;
    logic       mem_to_reg;
    logic       pcsrc;
    logic       jump1;
    logic       jump2;
    logic       mem_read;
    logic       mem_write;
    logic       pc_write;
    logic       ir_write;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output reg_dst, data_to_write, reg_write, alusrc, alu_op, mem_to_reg, pcsrc,
               jump1, jump2, mem_read, mem_write, pc_write, ir_write, trap, trap_cause
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  reg_dst, data_to_write, reg_write, alusrc, alu_op, mem_to_reg, pcsrc,
               jump1, jump2, mem_read, mem_write, pc_write, ir_write, trap, trap_cause
    );
endinterface

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM: fetch, decode, execute, memory, write-back.
// Traps on an illegal instruction or on a memory wait longer than MEM_TIMEOUT cycles.
// Optional feature macro MC_PERF_CNT_EN adds cycle_cnt and instr_cnt outputs.
module mips_mc_controller #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_mc_controller_if.master bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          instr_cnt
`endif
);

    localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;
    localparam logic [5:0] FnJr  = 6'b001000;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b100;

    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseTimeout = 2'b10;

    typedef enum logic [3:0] {
        StStart, StFetch, StDecode, StExecR, StWbR, StExecI, StWbI,
        StMemAddr, StMemRd, StMemWr, StBranch, StJump, StTrap
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [1:0] cause_q, cause_d;

    logic       is_jr;
    logic       is_jal;
    logic       mem_timeout;
    logic [2:0] r_alu_op;

    assign is_jr       = (bus.opcode == OpRtype) && (bus.funct == FnJr);
    assign is_jal      = (bus.opcode == OpJal);
    // Count reached while memory is still busy; ready in the same cycle still wins.
    assign mem_timeout = !bus.mem_ready && (wait_q == TimeoutCnt);

    // ALU operation for R-type arithmetic, taken from funct.
    always_comb begin
        r_alu_op = AluAdd;
        case (bus.funct)
            FnSub:   r_alu_op = AluSub;
            FnAnd:   r_alu_op = AluAnd;
            FnOr:    r_alu_op = AluOr;
            FnSlt:   r_alu_op = AluSlt;
            default: r_alu_op = AluAdd;
        endcase
    end

    // State, wait counter and trap cause registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StStart;
            wait_q  <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d           = state_q;
        wait_d            = '0;
        cause_d           = cause_q;
        bus.reg_dst       = 2'b00;
        bus.data_to_write = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alusrc        = 1'b0;
        bus.alu_op        = AluAdd;
        bus.mem_to_reg    = 1'b0;
        bus.pcsrc         = 1'b0;
        bus.jump1         = 1'b0;
        bus.jump2         = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.pc_write      = 1'b0;
        bus.ir_write      = 1'b0;
        bus.trap          = 1'b0;
        bus.trap_cause    = 2'b00;

        unique case (state_q)
            StStart: state_d = StFetch;

            StFetch: begin
                bus.mem_read = 1'b1;
                bus.ir_write = bus.mem_ready;
                if (!bus.mem_ready) wait_d = wait_q + 8'd1;
                if (bus.mem_ready) begin
                    state_d = StDecode;
                end else if (mem_timeout) begin
                    state_d = StTrap;
                    cause_d = CauseTimeout;
                end
            end

            StDecode: begin
                if (bus.opcode == OpRtype) begin
                    case (bus.funct)
                        FnAdd, FnSub, FnAnd, FnOr, FnSlt: state_d = StExecR;
                        FnJr:                             state_d = StJump;
                        default: begin
                            state_d = StTrap;
                            cause_d = CauseIllegal;
                        end
                    endcase
                end else begin
                    case (bus.opcode)
                        OpAddi, OpSlti: state_d = StExecI;
                        OpLw, OpSw:     state_d = StMemAddr;
                        OpBeq:          state_d = StBranch;
                        OpJ, OpJal:     state_d = StJump;
                        default: begin
                            state_d = StTrap;
                            cause_d = CauseIllegal;
                        end
                    endcase
                end
            end

            StExecR: begin
                bus.alu_op = r_alu_op;
                state_d    = StWbR;
            end

            StWbR: begin
                bus.alu_op    = r_alu_op;
                bus.reg_dst   = 2'b01;
                bus.reg_write = 1'b1;
                bus.pc_write  = 1'b1;
                state_d       = StFetch;
            end

            StExecI: begin
                bus.alusrc = 1'b1;
                bus.alu_op = (bus.opcode == OpSlti) ? AluSlt : AluAdd;
                state_d    = StWbI;
            end

            StWbI: begin
                bus.alusrc    = 1'b1;
                bus.alu_op    = (bus.opcode == OpSlti) ? AluSlt : AluAdd;
                bus.reg_write = 1'b1;
                bus.pc_write  = 1'b1;
                state_d       = StFetch;
            end

            StMemAddr: begin
                bus.alusrc = 1'b1;
                state_d    = (bus.opcode == OpLw) ? StMemRd : StMemWr;
            end

            StMemRd: begin
                bus.alusrc     = 1'b1;
                bus.mem_read   = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
                if (!bus.mem_ready) wait_d = wait_q + 8'd1;
                if (bus.mem_ready) begin
                    state_d = StFetch;
                end else if (mem_timeout) begin
                    state_d = StTrap;
                    cause_d = CauseTimeout;
                end
            end

            StMemWr: begin
                bus.alusrc    = 1'b1;
                bus.mem_write = 1'b1;
                bus.pc_write  = bus.mem_ready;
                if (!bus.mem_ready) wait_d = wait_q + 8'd1;
                if (bus.mem_ready) begin
                    state_d = StFetch;
                end else if (mem_timeout) begin
                    state_d = StTrap;
                    cause_d = CauseTimeout;
                end
            end

            StBranch: begin
                bus.alu_op   = AluSub;
                bus.pcsrc    = bus.zero;
                bus.pc_write = 1'b1;
                state_d      = StFetch;
            end

            StJump: begin
                bus.jump2         = 1'b1;
                bus.jump1         = is_jr;
                bus.pc_write      = 1'b1;
                bus.reg_dst       = is_jal ? 2'b10 : 2'b00;
                bus.data_to_write = is_jal;
                bus.reg_write     = is_jal;
                state_d           = StFetch;
            end

            StTrap: begin
                bus.trap       = 1'b1;
                bus.trap_cause = cause_q;
            end

            default: state_d = StStart;
        endcase
    end

`ifdef MC_PERF_CNT_EN
    // Performance counters: active cycles and retired instructions (one PC write each).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state_q != StStart && state_q != StTrap) cycle_cnt <= cycle_cnt + 32'd1;
            if (bus.pc_write) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: each stimulus cycle pushes the expected control
// vector; a monitor pops and compares on every falling edge.
module tb_mips_mc_controller;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic       data_to_write;
        logic       reg_write;
        logic       alusrc;
        logic [2:0] alu_op;
        logic       mem_to_reg;
        logic       pcsrc;
        logic       jump1;
        logic       jump2;
        logic       mem_read;
        logic       mem_write;
        logic       pc_write;
        logic       ir_write;
        logic       trap;
        logic [1:0] trap_cause;
    } ctl_t;

    typedef struct {
        ctl_t v;
        int   id;
    } exp_t;

    localparam logic [5:0] OpR = 6'b000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;
    int   step_id = 0;
    exp_t exp_q[$];

    mips_mc_controller_if bus();

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    mips_mc_controller #(
        .MEM_TIMEOUT(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.master)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic ctl_t c_zero();
        ctl_t c = '0;
        return c;
    endfunction

    function automatic ctl_t c_fetch(input logic rdy);
        ctl_t c = '0;
        c.mem_read = 1'b1;
        c.ir_write = rdy;
        return c;
    endfunction

    function automatic ctl_t c_exec(input logic src, input logic [2:0] aop);
        ctl_t c = '0;
        c.alusrc = src;
        c.alu_op = aop;
        return c;
    endfunction

    function automatic ctl_t c_wb(input logic [1:0] rdst, input logic src, input logic [2:0] aop);
        ctl_t c = '0;
        c.reg_dst   = rdst;
        c.alusrc    = src;
        c.alu_op    = aop;
        c.reg_write = 1'b1;
        c.pc_write  = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_mem_rd(input logic rdy);
        ctl_t c = '0;
        c.alusrc     = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = rdy;
        c.pc_write   = rdy;
        return c;
    endfunction

    function automatic ctl_t c_mem_wr(input logic rdy);
        ctl_t c = '0;
        c.alusrc    = 1'b1;
        c.mem_write = 1'b1;
        c.pc_write  = rdy;
        return c;
    endfunction

    function automatic ctl_t c_branch(input logic z);
        ctl_t c = '0;
        c.alu_op   = 3'b001;
        c.pcsrc    = z;
        c.pc_write = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_jump(input logic jr, input logic jal);
        ctl_t c = '0;
        c.jump2         = 1'b1;
        c.jump1         = jr;
        c.pc_write      = 1'b1;
        c.reg_dst       = jal ? 2'b10 : 2'b00;
        c.data_to_write = jal;
        c.reg_write     = jal;
        return c;
    endfunction

    function automatic ctl_t c_trap(input logic [1:0] cause);
        ctl_t c = '0;
        c.trap       = 1'b1;
        c.trap_cause = cause;
        return c;
    endfunction

    // One clock of stimulus: drive inputs just after the rising edge and queue the expectation.
    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input ctl_t e);
        exp_t x;
        @(posedge clk);
        #1;
        rst           = r;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = z;
        bus.mem_ready = rdy;
        x.v = e;
        x.id = step_id;
        exp_q.push_back(x);
        step_id++;
    endtask

    task automatic do_reset();
        step(1'b0, OpR, 6'd0, 1'b0, 1'b0, c_zero());
        step(1'b0, OpR, 6'd0, 1'b0, 1'b0, c_zero());
        step(1'b1, OpR, 6'd0, 1'b0, 1'b1, c_zero());
    endtask

    task automatic run_r(input logic [5:0] fn, input logic [2:0] aop);
        step(1'b1, OpR, fn, 1'b0, 1'b1, c_fetch(1'b1));
        step(1'b1, OpR, fn, 1'b0, 1'b1, c_zero());
        step(1'b1, OpR, fn, 1'b0, 1'b1, c_exec(1'b0, aop));
        step(1'b1, OpR, fn, 1'b0, 1'b1, c_wb(2'b01, 1'b0, aop));
    endtask

    task automatic run_i(input logic [5:0] op, input logic [2:0] aop);
        step(1'b1, op, 6'd0, 1'b0, 1'b1, c_fetch(1'b1));
        step(1'b1, op, 6'd0, 1'b0, 1'b1, c_zero());
        step(1'b1, op, 6'd0, 1'b0, 1'b1, c_exec(1'b1, aop));
        step(1'b1, op, 6'd0, 1'b0, 1'b1, c_wb(2'b00, 1'b1, aop));
    endtask

    // lw/sw with a number of wait cycles in FETCH and in the memory state.
    task automatic run_mem(input logic lw, input int f_waits, input int m_waits);
        logic [5:0] op;
        op = lw ? 6'b100011 : 6'b101011;
        for (int i = 0; i < f_waits; i++) step(1'b1, op, 6'd0, 1'b0, 1'b0, c_fetch(1'b0));
        step(1'b1, op, 6'd0, 1'b0, 1'b1, c_fetch(1'b1));
        step(1'b1, op, 6'd0, 1'b0, 1'b1, c_zero());
        step(1'b1, op, 6'd0, 1'b0, 1'b1, c_exec(1'b1, 3'b000));
        for (int i = 0; i < m_waits; i++)
            step(1'b1, op, 6'd0, 1'b0, 1'b0, lw ? c_mem_rd(1'b0) : c_mem_wr(1'b0));
        step(1'b1, op, 6'd0, 1'b0, 1'b1, lw ? c_mem_rd(1'b1) : c_mem_wr(1'b1));
    endtask

    task automatic run_beq(input logic z);
        step(1'b1, 6'b000100, 6'd0, z, 1'b1, c_fetch(1'b1));
        step(1'b1, 6'b000100, 6'd0, z, 1'b1, c_zero());
        step(1'b1, 6'b000100, 6'd0, z, 1'b1, c_branch(z));
    endtask

    task automatic run_jump(input logic [5:0] op, input logic [5:0] fn, input logic jr,
                            input logic jal);
        step(1'b1, op, fn, 1'b0, 1'b1, c_fetch(1'b1));
        step(1'b1, op, fn, 1'b0, 1'b1, c_zero());
        step(1'b1, op, fn, 1'b0, 1'b1, c_jump(jr, jal));
    endtask

    logic [5:0] r_fn [5];
    logic [2:0] r_op [5];

    initial begin
        bus.opcode    = OpR;
        bus.funct     = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        r_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        r_op = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};

        fork
            begin : monitor
                exp_t x;
                ctl_t act;
                forever begin
                    @(negedge clk);
                    if (exp_q.size() > 0) begin
                        x = exp_q.pop_front();
                        act = '{bus.reg_dst, bus.data_to_write, bus.reg_write, bus.alusrc,
                                bus.alu_op, bus.mem_to_reg, bus.pcsrc, bus.jump1, bus.jump2,
                                bus.mem_read, bus.mem_write, bus.pc_write, bus.ir_write,
                                bus.trap, bus.trap_cause};
                        n_total++;
                        if (act !== x.v) begin
                            n_bad++;
                            $display("FAIL ctl step %0d: got %b want %b", x.id, act, x.v);
                        end
                    end
                end
            end
        join_none

        // Reset state, then each R-type ALU op.
        do_reset();
        for (int i = 0; i < 5; i++) run_r(r_fn[i], r_op[i]);
        // Immediate forms.
        run_i(6'b001000, 3'b000);
        run_i(6'b001010, 3'b100);
        // lw with 3 waits (7 cycles), lw ready exactly at the timeout count, sw variants.
        run_mem(1'b1, 0, 3);
        run_mem(1'b1, 0, 4);
        run_mem(1'b0, 0, 0);
        run_mem(1'b0, 2, 1);
        // Branch taken / not taken, jal, jr, j.
        run_beq(1'b1);
        run_beq(1'b0);
        run_jump(6'b000011, 6'd0, 1'b0, 1'b1);
        run_jump(OpR, 6'b001000, 1'b1, 1'b0);
        run_jump(6'b000010, 6'd0, 1'b0, 1'b0);

        // Illegal opcode traps and holds regardless of inputs.
        step(1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, c_fetch(1'b1));
        step(1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, c_zero());
        step(1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, c_trap(2'b01));
        step(1'b1, OpR, 6'b100000, 1'b1, 1'b0, c_trap(2'b01));
        step(1'b1, 6'b100011, 6'd0, 1'b0, 1'b1, c_trap(2'b01));

        // Unknown R-type funct.
        do_reset();
        step(1'b1, OpR, 6'b111111, 1'b0, 1'b1, c_fetch(1'b1));
        step(1'b1, OpR, 6'b111111, 1'b0, 1'b1, c_zero());
        step(1'b1, OpR, 6'b111111, 1'b0, 1'b1, c_trap(2'b01));

        // Memory timeout in FETCH: four waits allowed, the fifth busy cycle traps.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, OpR, 6'd0, 1'b0, 1'b0, c_fetch(1'b0));
        step(1'b1, OpR, 6'd0, 1'b0, 1'b0, c_trap(2'b10));
        step(1'b1, OpR, 6'd0, 1'b0, 1'b1, c_trap(2'b10));
        step(1'b1, OpR, 6'd0, 1'b0, 1'b1, c_trap(2'b10));

        // Reset in MEM_RD with memory ready: no register write or PC write leaks out.
        do_reset();
        step(1'b1, 6'b100011, 6'd0, 1'b0, 1'b1, c_fetch(1'b1));
        step(1'b1, 6'b100011, 6'd0, 1'b0, 1'b1, c_zero());
        step(1'b1, 6'b100011, 6'd0, 1'b0, 1'b1, c_exec(1'b1, 3'b000));
        step(1'b0, 6'b100011, 6'd0, 1'b0, 1'b1, c_zero());

        // add, sw, j with zero-wait memory, then back in FETCH.
        do_reset();
        run_r(6'b100000, 3'b000);
        run_mem(1'b0, 0, 0);
        run_jump(6'b000010, 6'd0, 1'b0, 1'b0);
        step(1'b1, OpR, 6'd0, 1'b0, 1'b1, c_fetch(1'b1));
`ifdef MC_PERF_CNT_EN
        @(negedge clk);
        #1;
        n_total++;
        if (cycle_cnt !== 32'd11) begin
            n_bad++;
            $display("FAIL cycle_cnt: got %0d want 11", cycle_cnt);
        end
        n_total++;
        if (instr_cnt !== 32'd3) begin
            n_bad++;
            $display("FAIL instr_cnt: got %0d want 3", instr_cnt);
        end
`endif

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Multi-cycle control FSM that sequences the MIPS datapath: fetch, decode, execute, memory access and write-back.
- Drives every datapath mux select, ALU op, register-file write, PC-write and IR-write enable.
- Supports a variable-latency memory through a mem_ready handshake and traps on illegal opcodes or memory timeout.
- Sits beside the datapath; decodes opcode/funct from the datapath instruction register.

Parameters:
- MEM_TIMEOUT, 255: max consecutive wait cycles in a memory state before trap; range 1..255; counter is 8 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- opcode  input  6  inst[31:26] from IR.
- funct  input  6  inst[5:0] from IR.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes current read/write this cycle.
- reg_dst  output  2  write-reg select: 0=rt, 1=rd, 2=r31.
- data_to_write  output  1  reg write data: 0=ALU/mem, 1=PC+4.
- reg_write  output  1  register-file write enable.
- alusrc  output  1  ALU B: 0=rt data, 1=sign-extended imm.
- alu_op  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- mem_to_reg  output  1  0=ALU result, 1=mem_in.
- pcsrc  output  1  1 selects branch target.
- jump1  output  1  jump source: 0=pseudo-direct target, 1=rs (jr).
- jump2  output  1  1 selects jump path.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- pc_write  output  1  PC load enable.
- ir_write  output  1  IR load enable.
- trap  output  1  sticky fault flag.
- trap_cause  output  2  00 none, 01 illegal instr, 10 mem timeout.

Behaviour:
- Moore FSM; all outputs decode combinationally from the state, plus mem_ready, zero, opcode and funct where noted. Outputs not listed for a state are 0.
- Reset (rst=0, async) forces state START and clears the wait counter, trap and trap_cause. All outputs are 0 in START. START→FETCH unconditionally.
- FETCH: mem_read=1; ir_write=mem_ready. Goes to DECODE when mem_ready=1, else stays.
- DECODE branches on opcode/funct:
  - R-type (add 100000, sub 100010, and 100100, or 100101, slt 101010) → EXEC_R.
  - R-type jr (001000) → JUMP.
  - addi 001000 / slti 001010 → EXEC_I.
  - lw 100011 / sw 101011 → MEM_ADDR.
  - beq 000100 → BRANCH.
  - j 000010 / jal 000011 → JUMP.
  - Anything else, including an unknown funct → TRAP with cause 01.
- EXEC_R: alusrc=0, alu_op from funct → WB_R.
- WB_R: as EXEC_R, plus reg_dst=1, reg_write=1, pc_write=1 → FETCH.
- EXEC_I: alusrc=1, alu_op = add (addi) or slt (slti) → WB_I.
- WB_I: as EXEC_I, plus reg_dst=0, reg_write=1, pc_write=1 → FETCH.
- MEM_ADDR: alusrc=1, alu_op=add → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: alusrc=1, add, mem_read=1, mem_to_reg=1, reg_dst=0. reg_write=pc_write=mem_ready. mem_ready=1 → FETCH.
- MEM_WR: alusrc=1, add, mem_write=1, pc_write=mem_ready. mem_ready=1 → FETCH.
- BRANCH: alusrc=0, alu_op=sub, pcsrc=zero, pc_write=1 → FETCH.
- JUMP: jump2=1, pc_write=1, jump1=1 only for jr. For jal also reg_dst=2, data_to_write=1, reg_write=1. → FETCH.
- TRAP: trap=1, trap_cause held, all other outputs 0; stays in TRAP until reset.
- The PC is written exactly once per instruction, in the final state, so PC+4 stays valid throughout the instruction.
- Zero-wait cycle counts: R/I/lw/sw = 4, beq/j/jal/jr = 3.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle in those states while mem_ready=0.
  - When it equals MEM_TIMEOUT with mem_ready still 0 → TRAP, cause 10.
  - mem_ready=1 in the same cycle the count is reached completes normally.
- Reset asserted mid-instruction aborts immediately: no partial write completes after rst falls.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- Defined: adds output ports cycle_cnt [31:0] and instr_cnt [31:0].
  - cycle_cnt increments every cycle the state is not START or TRAP.
  - instr_cnt increments on each pc_write=1 cycle.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then add (op 000000, funct 100000), mem_ready tied 1 → states START, FETCH, DECODE, EXEC_R, WB_R; in WB_R reg_dst=1, reg_write=1, pc_write=1, alu_op=000.
- lw with mem_ready low for 3 cycles in MEM_RD → reg_write and pc_write stay 0 for 3 cycles, then pulse for one cycle with mem_to_reg=1; 7 cycles total.
- beq with zero=1, then beq with zero=0 → pcsrc=1 vs pcsrc=0, pc_write=1 both times, 3 cycles each.
- jal then jr → jal: jump2=1, jump1=0, reg_dst=2, data_to_write=1, reg_write=1; jr: jump2=1, jump1=1, reg_write=0.
- Opcode 111111, then a separate run with MEM_TIMEOUT=4 and mem_ready held 0 in FETCH → trap=1 with cause 01 (first case) or 10 after 4 wait cycles (second case); both hold until rst=0.
- Under MC_PERF_CNT_EN, run add, sw, j with zero-wait memory → instr_cnt=3, cycle_cnt=11 at the return to FETCH.
